// File: rtl/bip_control.sv
// bip_control: program counter and FETCH/EXEC instruction decoder for the
// BIP accumulator datapath. One instruction completes every two enabled
// cycles. Decode strobes are combinational from the program-memory read data
// and are only active in EXEC while i_enable is high.
//
// Optional feature macro: BIP_CONTROL_INSTR_COUNT_EN
//   When defined, adds o_instr_count, a saturating 32-bit count of executed
//   instructions (including NOP and HLT).
module bip_control #(
  parameter int N_BUS  = 16,
  parameter int N_ADDR = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_enable,
  input  logic [N_BUS-1:0]  i_instruction,
  output logic [N_ADDR-1:0] o_pc_addr,
  output logic [N_ADDR-1:0] o_operand,
  output logic [1:0]        o_selA,
  output logic              o_selB,
  output logic              o_op,
  output logic              o_wrAcc,
  output logic              o_wrRam,
  output logic              o_rdRam,
  output logic              o_halt
`ifdef BIP_CONTROL_INSTR_COUNT_EN
  ,
  output logic [31:0]       o_instr_count
`endif
);

  localparam int N_OP = N_BUS - N_ADDR;

  localparam logic [N_OP-1:0] OP_HLT  = N_OP'(0);
  localparam logic [N_OP-1:0] OP_STO  = N_OP'(1);
  localparam logic [N_OP-1:0] OP_LD   = N_OP'(2);
  localparam logic [N_OP-1:0] OP_LDI  = N_OP'(3);
  localparam logic [N_OP-1:0] OP_ADD  = N_OP'(4);
  localparam logic [N_OP-1:0] OP_ADDI = N_OP'(5);
  localparam logic [N_OP-1:0] OP_SUB  = N_OP'(6);
  localparam logic [N_OP-1:0] OP_SUBI = N_OP'(7);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Strobe bundle packing: {selA[1:0], selB, op, wrAcc, wrRam, rdRam}
  function automatic logic [6:0] decode(input logic [N_OP-1:0] opcode);
    logic [6:0] stb;
    case (opcode)
      OP_HLT:  stb = 7'b00_0_0_0_0_0;
      OP_STO:  stb = 7'b00_0_0_0_1_0;
      OP_LD:   stb = 7'b00_0_0_1_0_1;
      OP_LDI:  stb = 7'b01_0_0_1_0_0;
      OP_ADD:  stb = 7'b10_0_0_1_0_1;
      OP_ADDI: stb = 7'b10_1_0_1_0_0;
      OP_SUB:  stb = 7'b10_0_1_1_0_1;
      OP_SUBI: stb = 7'b10_1_1_1_0_0;
      default: stb = 7'b00_0_0_0_0_0;
    endcase
    return stb;
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  logic [N_ADDR-1:0] pc_r;
  logic [N_ADDR-1:0] pc_next_s;
  logic [6:0]        strobes_s;
  logic              exec_active_s;
  logic [N_OP-1:0]   opcode_s;

  assign opcode_s      = i_instruction[N_BUS-1:N_ADDR];
  assign exec_active_s = (state_r == S_EXEC) && i_enable;

  // State and program-counter registers; asynchronous reset to IDLE / PC 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      pc_r    <= {N_ADDR{1'b0}};
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
    end
  end

  // Next-state, PC advance and enable-gated decode strobes.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    strobes_s    = 7'b0;
    case (state_r)
      S_IDLE: begin
        if (i_enable && i_start) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (i_enable) begin
          state_next_s = S_EXEC;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_EXEC: begin
        if (i_enable) begin
          strobes_s = decode(opcode_s);
          if (opcode_s == OP_HLT) begin
            state_next_s = S_HALT;
          end else begin
            state_next_s = S_FETCH;
            // Natural N_ADDR-bit wrap gives 2^N_ADDR-1 -> 0.
            pc_next_s    = pc_r + {{(N_ADDR-1){1'b0}}, 1'b1};
          end
        end else begin
          state_next_s = S_EXEC;
        end
      end
      S_HALT: begin
        state_next_s = S_HALT;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  assign o_pc_addr = pc_r;
  assign o_operand = (state_r == S_EXEC) ? i_instruction[N_ADDR-1:0] : {N_ADDR{1'b0}};
  assign o_selA    = strobes_s[6:5];
  assign o_selB    = strobes_s[4];
  assign o_op      = strobes_s[3];
  assign o_wrAcc   = strobes_s[2];
  assign o_wrRam   = strobes_s[1];
  assign o_rdRam   = strobes_s[0];
  assign o_halt    = (state_r == S_HALT);

`ifdef BIP_CONTROL_INSTR_COUNT_EN
  logic [31:0] instr_count_r;

  // Saturating count of executed instructions; HALT never reaches EXEC so it holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instr_count_r <= 32'd0;
    end else if (exec_active_s && (instr_count_r != 32'hFFFF_FFFF)) begin
      instr_count_r <= instr_count_r + 32'd1;
    end else begin
      instr_count_r <= instr_count_r;
    end
  end

  assign o_instr_count = instr_count_r;
`endif

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: a table of instructions with their
// expected decode is loaded into a program-memory model, expectations are
// queued and compared per FETCH/EXEC pair, followed by hand-written stall,
// PC-wrap and mid-EXEC reset sequences.
module tb_bip_control;

  localparam int N_BUS  = 16;
  localparam int N_ADDR = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              enable;
  logic [N_BUS-1:0]  instr;
  logic [N_ADDR-1:0] pc_addr;
  logic [N_ADDR-1:0] operand;
  logic [1:0]        sel_a;
  logic              sel_b;
  logic              op;
  logic              wr_acc;
  logic              wr_ram;
  logic              rd_ram;
  logic              halt;
`ifdef BIP_CONTROL_INSTR_COUNT_EN
  logic [31:0]       instr_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int wr_pulses = 0;

  logic [N_BUS-1:0] prog [0:2047];
  logic [6:0]       strobes;

  assign strobes = {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram};

  bip_control #(.N_BUS(N_BUS), .N_ADDR(N_ADDR)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_enable      (enable),
    .i_instruction (instr),
    .o_pc_addr     (pc_addr),
    .o_operand     (operand),
    .o_selA        (sel_a),
    .o_selB        (sel_b),
    .o_op          (op),
    .o_wrAcc       (wr_acc),
    .o_wrRam       (wr_ram),
    .o_rdRam       (rd_ram),
    .o_halt        (halt)
`ifdef BIP_CONTROL_INSTR_COUNT_EN
    ,
    .o_instr_count (instr_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous program memory: address registered every rising edge.
  always @(posedge clk) begin
    instr <= prog[pc_addr];
  end

  // Count data-memory writes actually taken at a clock edge.
  always @(posedge clk) begin
    if (wr_ram) wr_pulses <= wr_pulses + 1;
  end

  // Overall time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [4:0]  opc;
    logic [10:0] opd;
    logic [6:0]  exp_stb;   // {selA, selB, op, wrAcc, wrRam, rdRam}
  } vec_t;

  typedef struct packed {
    logic [10:0] pc;
    logic [10:0] opd;
    logic [6:0]  stb;
  } sb_t;

  vec_t vecs [10];
  sb_t  sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_nop();
    for (int a = 0; a < 2048; a++) prog[a] = 16'hF800;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulse start; returns at the negedge inside the first FETCH.
  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    sb_t e;
    int  base;
    rst_n  = 1'b0;
    start  = 1'b0;
    enable = 1'b1;

    vecs[0] = '{5'b00011, 11'd5,    7'b01_0_0_1_0_0};  // LDI 5
    vecs[1] = '{5'b00101, 11'd3,    7'b10_1_0_1_0_0};  // ADDI 3
    vecs[2] = '{5'b00010, 11'd7,    7'b00_0_0_1_0_1};  // LD 7
    vecs[3] = '{5'b00110, 11'd7,    7'b10_0_1_1_0_1};  // SUB 7
    vecs[4] = '{5'b00001, 11'd9,    7'b00_0_0_0_1_0};  // STO 9
    vecs[5] = '{5'b00100, 11'd4,    7'b10_0_0_1_0_1};  // ADD 4
    vecs[6] = '{5'b00111, 11'd2,    7'b10_1_1_1_0_0};  // SUBI 2
    vecs[7] = '{5'b01000, 11'd3,    7'b00_0_0_0_0_0};  // NOP (01000)
    vecs[8] = '{5'b11111, 11'd2047, 7'b00_0_0_0_0_0};  // NOP (11111)
    vecs[9] = '{5'b00000, 11'd5,    7'b00_0_0_0_0_0};  // HLT

    // ---------------- Reset state ----------------
    fill_nop();
    repeat (2) @(negedge clk);
    chk("reset_pc", 32'(pc_addr), 32'd0);
    chk("reset_strobes", 32'(strobes), 32'd0);
    chk("reset_halt", 32'(halt), 32'd0);
    chk("reset_operand", 32'(operand), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start_pc", 32'(pc_addr), 32'd0);
    chk("idle_no_start_strobes", 32'(strobes), 32'd0);

    // ---------------- Table-driven program ----------------
    for (int i = 0; i < 10; i++) begin
      prog[i] = {vecs[i].opc, vecs[i].opd};
      sb_q.push_back('{pc: 11'(i), opd: vecs[i].opd, stb: vecs[i].exp_stb});
    end
    kick();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("fetch_pc", 32'(pc_addr), 32'(e.pc));
      chk("fetch_strobes", 32'(strobes), 32'd0);
      chk("fetch_operand", 32'(operand), 32'd0);
      @(negedge clk);
      chk("exec_pc", 32'(pc_addr), 32'(e.pc));
      chk("exec_operand", 32'(operand), 32'(e.opd));
      chk("exec_strobes", 32'(strobes), 32'(e.stb));
      chk("exec_halt", 32'(halt), 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      chk("halt_high", 32'(halt), 32'd1);
      chk("halt_pc", 32'(pc_addr), 32'd9);
      chk("halt_strobes", 32'(strobes), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
`ifdef BIP_CONTROL_INSTR_COUNT_EN
    chk("instr_count", instr_count, 32'd10);
    repeat (10) @(negedge clk);
    chk("instr_count_hold", instr_count, 32'd10);
`endif

    // ---------------- Stall during STO EXEC ----------------
    do_reset();
    fill_nop();
    prog[0] = {5'b00001, 11'd9};
    prog[1] = {5'b00000, 11'd0};
    base = wr_pulses;
    kick();
    @(negedge clk);                    // now in EXEC of STO
    chk("stall_exec_operand", 32'(operand), 32'd9);
    enable = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_wrram", 32'(wr_ram), 32'd0);
      chk("stall_pc", 32'(pc_addr), 32'd0);
      @(negedge clk);
    end
    enable = 1'b1;
    #1;
    chk("stall_release_wrram", 32'(wr_ram), 32'd1);
    chk("stall_release_wracc", 32'(wr_acc), 32'd0);
    @(negedge clk);
    chk("stall_next_pc", 32'(pc_addr), 32'd1);
    repeat (2) @(negedge clk);
    chk("stall_halt", 32'(halt), 32'd1);
    chk("stall_wr_pulses", 32'(wr_pulses - base), 32'd1);

    // ---------------- PC wrap 2047 -> 0 ----------------
    do_reset();
    fill_nop();
    kick();
    repeat (2 * 2047) @(negedge clk);
    chk("wrap_fetch_pc", 32'(pc_addr), 32'd2047);
    @(negedge clk);
    chk("wrap_exec_pc", 32'(pc_addr), 32'd2047);
    chk("wrap_exec_strobes", 32'(strobes), 32'd0);
    @(negedge clk);
    chk("wrap_pc_zero", 32'(pc_addr), 32'd0);
    chk("wrap_strobes", 32'(strobes), 32'd0);
    chk("wrap_halt", 32'(halt), 32'd0);
`ifdef BIP_CONTROL_INSTR_COUNT_EN
    chk("wrap_instr_count", instr_count, 32'd2048);
`endif

    // ---------------- Reset asserted mid ADD EXEC ----------------
    do_reset();
    fill_nop();
    prog[0] = {5'b00011, 11'd1};   // LDI 1
    prog[1] = {5'b00100, 11'd4};   // ADD 4
    kick();
    repeat (3) @(negedge clk);     // EXEC of ADD at PC 1
    chk("mid_add_pc", 32'(pc_addr), 32'd1);
    chk("mid_add_wracc", 32'(wr_acc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wracc", 32'(wr_acc), 32'd0);
    chk("mid_rst_strobes", 32'(strobes), 32'd0);
    chk("mid_rst_pc", 32'(pc_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_pc", 32'(pc_addr), 32'd0);
      chk("post_rst_strobes", 32'(strobes), 32'd0);
      chk("post_rst_operand", 32'(operand), 32'd0);
      chk("post_rst_halt", 32'(halt), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_control.md
# bip_control

Program counter and instruction-decode control unit for the BIP accumulator datapath. It fetches 16-bit instructions from synchronous program memory and decodes them into the accumulator-input select, operand-B select, ALU opcode, accumulator write enable and data-memory strobes. It sits directly upstream of the accumulator input multiplexer and drives its 2-bit select. One instruction completes every two enabled cycles, in a FETCH/EXEC sequence.

## Interface
- N_BUS, 16, instruction width; opcode is [N_BUS-1:N_ADDR], operand is [N_ADDR-1:0]
- N_ADDR, 11, program/data address and operand width
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  leaves IDLE; ignored in every other state
- i_enable  in  1  step enable; low freezes state and PC
- i_instruction  in  N_BUS  program-memory read data, valid one cycle after o_pc_addr
- o_pc_addr  out  N_ADDR  program-memory address (= PC)
- o_operand  out  N_ADDR  instruction[N_ADDR-1:0] in EXEC, else 0
- o_selA  out  2  accumulator-input select: 00 data memory, 01 immediate, 10 ALU result
- o_selB  out  1  ALU operand B: 0 data memory, 1 immediate
- o_op  out  1  ALU op: 0 add, 1 subtract
- o_wrAcc  out  1  accumulator write enable
- o_wrRam  out  1  data-memory write strobe
- o_rdRam  out  1  data-memory read strobe
- o_halt  out  1  high in HALT

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Transitions:
  - IDLE→FETCH on i_start.
  - FETCH→EXEC.
  - EXEC→FETCH, or EXEC→HALT on opcode HLT.
  - HALT exits only on reset.
- All transitions and PC updates require i_enable=1. With i_enable=0, state and PC hold and all strobes are 0.
- Strobes are decoded combinationally from i_instruction, gated by state==EXEC && i_enable. They are 0 in all other states.
- Opcode decode (5 bits):
  - 00000 HLT: no strobes.
  - 00001 STO: wrRam=1.
  - 00010 LD: rdRam=1, selA=00, wrAcc=1.
  - 00011 LDI: selA=01, wrAcc=1.
  - 00100 ADD: rdRam=1, selB=0, op=0, selA=10, wrAcc=1.
  - 00101 ADDI: selB=1, op=0, selA=10, wrAcc=1.
  - 00110 SUB: rdRam=1, selB=0, op=1, selA=10, wrAcc=1.
  - 00111 SUBI: selB=1, op=1, selA=10, wrAcc=1.
  - Any other opcode: NOP (no strobes); PC still advances.
- Outputs not listed for an opcode are 0, including selA/selB.
- PC increments by 1 at the EXEC→FETCH edge, modulo 2^N_ADDR (2047→0). It does not increment on HLT.
- Sign extension of o_operand is performed downstream, not here.

## Timing
- Reset (asynchronous, takes effect immediately): state IDLE, PC=0, and every output 0 (o_halt=0, o_selA=00).
- i_start sampled high in IDLE → FETCH on the next edge; o_pc_addr=PC throughout FETCH and EXEC.
- Program memory registers the address at the FETCH edge. i_instruction is valid throughout EXEC.
- Latency: strobes are asserted for exactly one enabled cycle per instruction. Throughput is 1 instruction per 2 enabled cycles.
- Stall in EXEC (i_enable=0): strobes drop to 0 and EXEC is held. The write is issued only in the cycle with i_enable=1, never twice.
- Reset asserted mid-EXEC: strobes drop in the same cycle (combinational gate on state), and PC returns to 0.
- o_halt rises the cycle after the HLT EXEC and stays high until reset.

## Configuration
- BIP_CONTROL_INSTR_COUNT_EN:
  - Defined: adds output o_instr_count [31:0]. It resets to 0 and increments by 1 on every EXEC edge with i_enable=1, including HLT and NOP. It saturates at 2^32-1 and holds its value in HALT.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then i_start=1, program {LDI 5, ADDI 3, HLT} → PC 0,0,1,1,2,2.
  - EXEC cycles show selA=01/wrAcc=1, then selA=10/selB=1/op=0/wrAcc=1, then no strobes.
  - o_halt=1 afterwards; PC stays 2.
- LD 7, SUB 7, STO 9 → operand 7 with rdRam=1/selA=00; operand 7 with rdRam=1/selB=0/op=1/selA=10; operand 9 with wrRam=1 and wrAcc=0.
- Drop i_enable for 3 cycles during STO EXEC → wrRam=0 while stalled and exactly one wrRam pulse in total; PC frozen.
- PC preloaded to 2047 via a NOP stream (opcode 11111) → after EXEC, o_pc_addr=0 with no strobes asserted.
- Assert i_rst_n=0 during ADD EXEC → wrAcc drops immediately, PC=0, state IDLE. A following i_start=0 keeps all outputs at 0.
- With BIP_CONTROL_INSTR_COUNT_EN defined, run 4 instructions then HLT → o_instr_count=5, unchanged 10 cycles later.
